// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU pipeline (priority) and a
// secondary DMA requester, with a starvation-driven one-cycle CPU freeze.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_in,
  output logic          cpu_en,
  input  logic [3:0]    cpu_mem_we,
  input  logic          cpu_mem_re,
  input  logic [AW-1:0] cpu_mem_addr,
  input  logic [31:0]   cpu_mem_wdata,
  output logic [31:0]   cpu_mem_rdata,
  input  logic          dma_req,
  input  logic [3:0]    dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [31:0]   dma_rdata,
  output logic [3:0]    mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic {NORMAL, FORCE} state_t;
  typedef enum logic [1:0] {NONE, CPU_RD, DMA_RD} own_t;

  localparam logic [7:0] LIM_M1 = 8'(STARVE_LIMIT - 1);

  state_t      state;
  own_t        last_own, own_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] cpu_rd_hold;
  logic        cpu_active, freeze, cpu_gnt, starve;

  assign cpu_active = cpu_mem_re | (|cpu_mem_we);
  assign freeze     = (state == FORCE) & dma_req;
  assign cpu_en     = en_in & ~freeze;
  assign cpu_gnt    = en_in & cpu_active & ~freeze;
  assign dma_gnt    = dma_req & ~cpu_gnt;
  assign starve     = (state == NORMAL) & dma_req & ~dma_gnt & (wait_cnt == LIM_M1);

  always_comb begin
    mem_we    = '0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    own_nxt   = NONE;
    if (cpu_gnt) begin
      mem_we    = cpu_mem_we;
      mem_re    = cpu_mem_re;
      mem_addr  = cpu_mem_addr;
      mem_wdata = cpu_mem_wdata;
      if (cpu_mem_re) own_nxt = CPU_RD;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_re    = (dma_we == 4'b0000);
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      if (dma_we == 4'b0000) own_nxt = DMA_RD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= NORMAL;
      wait_cnt    <= '0;
      last_own    <= NONE;
      cpu_rd_hold <= '0;
    end else begin
      case (state)
        NORMAL:  if (starve) state <= FORCE;
        default: state <= NORMAL;
      endcase
      // Entry to FORCE restarts the count, so forced cycles can never be adjacent.
      if (starve || dma_gnt || !dma_req) wait_cnt <= '0;
      else if (wait_cnt != LIM_M1)       wait_cnt <= wait_cnt + 8'd1;
      last_own <= own_nxt;
      // Keeps a completed load visible while the pipeline is frozen.
      if (last_own == CPU_RD) cpu_rd_hold <= mem_rdata;
    end
  end

  assign cpu_mem_rdata = (last_own == CPU_RD) ? mem_rdata : cpu_rd_hold;
  assign dma_rvalid    = (last_own == DMA_RD);
  assign dma_rdata     = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed test of dmem_arbiter: CPU load/hold, idle-slot DMA, starvation freeze,
// reset during FORCE, and DMA write while the pipeline enable is low.
module tb_dmem_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_in;
  logic          cpu_en;
  logic [3:0]    cpu_mem_we;
  logic          cpu_mem_re;
  logic [AW-1:0] cpu_mem_addr;
  logic [31:0]   cpu_mem_wdata;
  logic [31:0]   cpu_mem_rdata;
  logic          dma_req;
  logic [3:0]    dma_we;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [31:0]   dma_rdata;
  logic [3:0]    mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.STARVE_LIMIT(8), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .cpu_en(cpu_en),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_re(cpu_mem_re), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_rdata(cpu_mem_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_mem_we = 4'h0; cpu_mem_re = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0; en_in = 1'b1;
    cpu_idle();
    dma_req = 1'b0; dma_we = 4'h0; dma_addr = '0; dma_wdata = '0; mem_rdata = '0;

    // Reset state
    #2;
    chk("rst_cpu_en", 32'(cpu_en), 32'd1);
    chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_cpu_rdata", cpu_mem_rdata, 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    dma_req = 1'b1; #1;
    chk("rst_dma_gnt_req", 32'(dma_gnt), 32'd1);
    dma_req = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;

    // CPU load only
    cyc();
    cpu_mem_re = 1'b1; cpu_mem_addr = 32'h40; #1;
    chk("ld_mem_addr", mem_addr, 32'h40);
    chk("ld_mem_re", 32'(mem_re), 32'd1);
    chk("ld_dma_gnt", 32'(dma_gnt), 32'd0);
    cyc();
    cpu_idle(); mem_rdata = 32'hDEADBEEF; #1;
    chk("ld_rdata_c1", cpu_mem_rdata, 32'hDEADBEEF);
    cyc();
    mem_rdata = 32'h55555555; #1;
    chk("ld_rdata_hold", cpu_mem_rdata, 32'hDEADBEEF);
    chk("ld_no_rvalid", 32'(dma_rvalid), 32'd0);
    chk("ld_idle_addr", mem_addr, 32'h0);

    // DMA read in an idle slot
    cyc();
    dma_req = 1'b1; dma_we = 4'h0; dma_addr = 32'h80; #1;
    chk("dma_gnt", 32'(dma_gnt), 32'd1);
    chk("dma_mem_addr", mem_addr, 32'h80);
    chk("dma_mem_re", 32'(mem_re), 32'd1);
    chk("dma_cpu_en", 32'(cpu_en), 32'd1);
    cyc();
    dma_req = 1'b0; mem_rdata = 32'hA5A50080; #1;
    chk("dma_rvalid", 32'(dma_rvalid), 32'd1);
    chk("dma_rdata", dma_rdata, 32'hA5A50080);
    chk("dma_cpu_hold", cpu_mem_rdata, 32'hDEADBEEF);
    chk("dma_cpu_en2", 32'(cpu_en), 32'd1);
    cyc();
    mem_rdata = 32'h0; #1;
    chk("dma_rvalid_off", 32'(dma_rvalid), 32'd0);

    // Starvation: CPU writes in cycles 0-6, reads 0x10 in cycle 7, DMA held throughout
    dma_req = 1'b1; dma_addr = 32'h200;
    for (int i = 0; i < 7; i++) begin
      cyc();
      cpu_mem_we = 4'hF; cpu_mem_addr = 32'h300 + 32'(i); cpu_mem_wdata = 32'(i); #1;
      chk("stv_dma_gnt", 32'(dma_gnt), 32'd0);
      chk("stv_cpu_en", 32'(cpu_en), 32'd1);
      chk("stv_mem_addr", mem_addr, 32'h300 + 32'(i));
    end
    cyc();
    cpu_mem_we = 4'h0; cpu_mem_re = 1'b1; cpu_mem_addr = 32'h10; #1;
    chk("c7_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("c7_mem_addr", mem_addr, 32'h10);
    // Cycle 8: FORCE; the load data returns while the CPU is frozen
    cyc();
    cpu_mem_re = 1'b0; cpu_mem_we = 4'hF; cpu_mem_addr = 32'h500; cpu_mem_wdata = 32'h77;
    mem_rdata = 32'h1234; #1;
    chk("c8_cpu_en", 32'(cpu_en), 32'd0);
    chk("c8_dma_gnt", 32'(dma_gnt), 32'd1);
    chk("c8_mem_addr", mem_addr, 32'h200);
    chk("c8_mem_we", 32'(mem_we), 32'h0);
    chk("c8_cpu_rdata", cpu_mem_rdata, 32'h1234);
    // Cycle 9: CPU re-presented and granted; DMA data on the bus; new DMA request
    cyc();
    dma_addr = 32'h204; mem_rdata = 32'hBEEF0200; #1;
    chk("c9_cpu_en", 32'(cpu_en), 32'd1);
    chk("c9_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("c9_mem_addr", mem_addr, 32'h500);
    chk("c9_mem_we", 32'(mem_we), 32'hF);
    chk("c9_rvalid", 32'(dma_rvalid), 32'd1);
    chk("c9_dma_rdata", dma_rdata, 32'hBEEF0200);
    chk("c9_cpu_hold", cpu_mem_rdata, 32'h1234);
    // Cycles 10-16 still denied; count restarted at cycle 9
    for (int i = 10; i <= 16; i++) begin
      cyc();
      mem_rdata = 32'h0; #1;
      chk("nobb_cpu_en", 32'(cpu_en), 32'd1);
      chk("nobb_dma_gnt", 32'(dma_gnt), 32'd0);
    end
    // Cycle 17: second FORCE, then reset asserted inside it
    cyc(); #1;
    chk("c17_cpu_en", 32'(cpu_en), 32'd0);
    chk("c17_dma_gnt", 32'(dma_gnt), 32'd1);
    chk("c17_mem_addr", mem_addr, 32'h204);
    rst_n = 1'b0; #1;
    chk("rstf_cpu_en", 32'(cpu_en), 32'd1);
    chk("rstf_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    chk("rstf_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("rstf_cpu_rdata", cpu_mem_rdata, 32'h0);
    // Release in cycle 18; cycles 18-25 are the 8 denied cycles, FORCE in 26
    cyc();
    rst_n = 1'b1;
    for (int i = 18; i <= 25; i++) begin
      #1;
      chk("post_cpu_en", 32'(cpu_en), 32'd1);
      chk("post_dma_gnt", 32'(dma_gnt), 32'd0);
      cyc();
    end
    #1;
    chk("c26_cpu_en", 32'(cpu_en), 32'd0);
    chk("c26_dma_gnt", 32'(dma_gnt), 32'd1);

    // DMA write with en_in low while CPU signals are active
    cyc();
    en_in = 1'b0; cpu_mem_re = 1'b1; cpu_mem_we = 4'hF; cpu_mem_addr = 32'h600;
    dma_we = 4'hF; dma_addr = 32'h700; dma_wdata = 32'hCAFEF00D; #1;
    chk("dw_dma_gnt", 32'(dma_gnt), 32'd1);
    chk("dw_mem_we", 32'(mem_we), 32'hF);
    chk("dw_mem_addr", mem_addr, 32'h700);
    chk("dw_mem_wdata", mem_wdata, 32'hCAFEF00D);
    chk("dw_mem_re", 32'(mem_re), 32'd0);
    chk("dw_cpu_en", 32'(cpu_en), 32'd0);
    cyc();
    dma_req = 1'b0; #1;
    chk("dw_no_rvalid", 32'(dma_rvalid), 32'd0);
    chk("dw_idle_we", 32'(mem_we), 32'h0);
    chk("dw_idle_addr", mem_addr, 32'h0);
    chk("dw_idle_gnt", 32'(dma_gnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the CPU's single data-memory port between the five-stage MIPS pipeline and one secondary requester, such as a DMA engine or accelerator. The CPU has priority. The secondary port uses idle cycles. A starvation counter forces a one-cycle CPU freeze, via the pipeline enable, when the secondary port has been denied too long. Sits between the CPU memory outputs and the data memory, and owns the CPU `en` input.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: consecutive denied DMA request cycles before a forced grant. Legal range is 1..255.
- `AW`, default 32: address width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en_in`  in  1  global pipeline enable from the top level.
- `cpu_en`  out  1  enable driven to the CPU.
- `cpu_mem_we`  in  4  CPU byte write enables.
- `cpu_mem_re`  in  1  CPU read enable.
- `cpu_mem_addr`  in  AW  CPU address.
- `cpu_mem_wdata`  in  32  CPU write data.
- `cpu_mem_rdata`  out  32  read data returned to the CPU MEM stage.
- `dma_req`  in  1  DMA access request, held until granted.
- `dma_we`  in  4  DMA byte write enables; all zero means a read.
- `dma_addr`  in  AW  DMA address.
- `dma_wdata`  in  32  DMA write data.
- `dma_gnt`  out  1  the DMA access is performed this cycle.
- `dma_rvalid`  out  1  `dma_rdata` is valid this cycle.
- `dma_rdata`  out  32  DMA read data.
- `mem_we`  out  4  memory byte write enables.
- `mem_re`  out  1  memory read enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid one cycle after `mem_re`.

## Operation
Definitions:
- `cpu_active` = `cpu_mem_re` | (OR-reduction of `cpu_mem_we`).
- `force` = (state == FORCE) & `dma_req`.

Enable:
- `cpu_en` = `en_in` & ~`force`. This is combinational.

Grant (combinational, exactly one owner or none):
- CPU grant: `cpu_gnt` = `en_in` & `cpu_active` & ~`force`.
- DMA grant: `dma_gnt` = `dma_req` & ~`cpu_gnt`.
- If `en_in` is 0, CPU requests are ignored and the DMA may proceed.

Memory mux:
- The granted requester drives `mem_we`, `mem_re`, `mem_addr` and `mem_wdata`.
- With no grant, all four outputs are 0.
- For a DMA grant, `mem_re` = (`dma_we` == 0).

FSM, two states:
- NORMAL moves to FORCE when `dma_req` & ~`dma_gnt` & `wait_cnt` == `STARVE_LIMIT`-1.
- FORCE moves to NORMAL unconditionally after one cycle.
- If `dma_req` is low in FORCE, there is no freeze and no grant.

Starvation counter `wait_cnt` (8 bits):
- Increments on `dma_req` & ~`dma_gnt`.
- Clears on `dma_gnt`, on ~`dma_req`, and on entry to FORCE.
- Saturates at `STARVE_LIMIT`-1.

Read return:
- Registered `last_own` takes one of NONE, CPU_RD or DMA_RD, recording which read was granted the previous cycle.
- `cpu_mem_rdata` = `mem_rdata` when `last_own` == CPU_RD, else `cpu_rd_hold`.
- `cpu_rd_hold` is a 32-bit register loaded with `mem_rdata` on every cycle where `last_own` == CPU_RD.
- This keeps a completed CPU load stable while the pipeline is frozen by FORCE or `en_in`=0.
- `dma_rvalid` = (`last_own` == DMA_RD).
- `dma_rdata` = `mem_rdata`, passed through combinationally.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state NORMAL, `wait_cnt` 0, `last_own` NONE, `cpu_rd_hold` 0.
  - Resulting outputs: `dma_rvalid` 0, `dma_gnt` 0 unless `dma_req` is high, `cpu_en` = `en_in`, `cpu_mem_rdata` 0.
- Grant-to-access latency is zero; `dma_gnt` is combinational from the current cycle's inputs.
- Read data reaches the requester one cycle after the grant.
- A write completes in its grant cycle.
- Worst-case DMA wait is `STARVE_LIMIT` denied cycles; the grant comes in the next cycle, the FORCE cycle.
- The CPU loses exactly one cycle per forced grant. A frozen CPU request is re-presented the following cycle and is granted then.
- Back-to-back FORCE cycles are impossible: after FORCE, `wait_cnt` restarts from 0.
- Reset asserted during FORCE returns the block to NORMAL immediately, with `cpu_en` = `en_in`.

## Test plan
- CPU load only:
  - Stimulus: cycle 0 drives `cpu_mem_re`=1, `cpu_mem_addr`=0x40; memory returns 0xDEADBEEF.
  - Required: `mem_addr`=0x40 in cycle 0; cycle 1 `cpu_mem_rdata`=0xDEADBEEF; cycle 2 onward, with CPU idle, still 0xDEADBEEF from the hold register.
- DMA in an idle slot:
  - Stimulus: `dma_req`=1, `dma_we`=0, `dma_addr`=0x80, CPU idle.
  - Required: `dma_gnt`=1 in the same cycle; next cycle `dma_rvalid`=1 with memory data; `cpu_en`=1 throughout.
- Starvation with `STARVE_LIMIT`=8:
  - Stimulus: CPU active every cycle, `dma_req` held from cycle 0.
  - Required: `dma_gnt`=0 in cycles 0–7; cycle 8 `cpu_en`=0 and `dma_gnt`=1; cycle 9 `cpu_en`=1 and the CPU is granted.
- Forced cycle right after a CPU load:
  - Stimulus: CPU read of 0x10 (data 0x1234) granted in cycle 7, FORCE in cycle 8.
  - Required: cycle 8 `cpu_mem_rdata`=0x1234; cycle 9 `cpu_mem_rdata` still 0x1234 while `mem_rdata` holds the DMA data.
- DMA write with `en_in`=0:
  - Stimulus: `dma_we`=4'b1111, CPU signals active.
  - Required: `mem_we`=4'b1111 with the DMA address and data; `dma_rvalid` stays 0.
- Reset in FORCE:
  - Stimulus: drop `rst_n` during a FORCE cycle.
  - Required: `cpu_en` returns to `en_in` immediately and `wait_cnt` is 0; after release, 8 more denied cycles are needed before the next force.
